// File: rtl/vx_mem_responder.sv
// Memory-bus slave endpoint: posted byte-enabled writes, reads answered in order after a fixed
// latency through a valid pipeline feeding a credit-protected response FIFO with bypass.
module vx_mem_responder #(
  parameter int unsigned DATA_SIZE  = 64,
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned TAG_WIDTH  = 8,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4,
  parameter int unsigned RSP_QUEUE  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mem_req_valid,
  input  logic                   mem_req_rw,
  input  logic [ADDR_WIDTH-1:0]  mem_req_addr,
  input  logic [DATA_SIZE-1:0]   mem_req_byteen,
  input  logic [DATA_SIZE*8-1:0] mem_req_data,
  input  logic [TAG_WIDTH-1:0]   mem_req_tag,
  output logic                   mem_req_ready,
  output logic                   mem_rsp_valid,
  output logic [DATA_SIZE*8-1:0] mem_rsp_data,
  output logic [TAG_WIDTH-1:0]   mem_rsp_tag,
  input  logic                   mem_rsp_ready,
  output logic                   busy
);

  localparam int unsigned DW    = DATA_SIZE * 8;
  localparam int unsigned QW    = $clog2(RSP_QUEUE);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [QW:0] QFULL = (QW + 1)'(RSP_QUEUE);

  logic                  reset_q;
  logic [QW:0]           pending;
  logic [DW-1:0]         mem [DEPTH];
  logic [DEPTH_LOG2-1:0] idx;
  logic                  req_fire, rd_fire, wr_fire, rsp_fire;

  logic [LATENCY-1:0]    pipe_vld;
  logic [DW-1:0]         pipe_data [LATENCY];
  logic [TAG_WIDTH-1:0]  pipe_tag  [LATENCY];
  logic                  out_vld;
  logic [DW-1:0]         out_data;
  logic [TAG_WIDTH-1:0]  out_tag;

  logic [DW-1:0]         q_data [RSP_QUEUE];
  logic [TAG_WIDTH-1:0]  q_tag  [RSP_QUEUE];
  logic [QW-1:0]         wptr, rptr;
  logic [QW:0]           count;
  logic                  q_empty, push, pop;

  // Upper address bits alias onto the same line.
  logic unused_addr;
  assign unused_addr = ^mem_req_addr[ADDR_WIDTH-1:DEPTH_LOG2];

  assign idx           = mem_req_addr[DEPTH_LOG2-1:0];
  assign mem_req_ready = !reset_q && (pending < QFULL);
  assign busy          = (pending != '0);
  assign req_fire      = mem_req_valid && mem_req_ready && !reset;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;

  always_ff @(posedge clk) begin
    reset_q <= reset;
  end

  // Line array and data pipeline carry no reset; validity lives in pipe_vld.
  always_ff @(posedge clk) begin
    if (wr_fire) begin
      for (int b = 0; b < int'(DATA_SIZE); b++) begin
        if (mem_req_byteen[b]) mem[idx][b*8 +: 8] <= mem_req_data[b*8 +: 8];
      end
    end
    if (rd_fire) begin
      pipe_data[0] <= mem[idx];
      pipe_tag[0]  <= mem_req_tag;
    end
    for (int i = 1; i < int'(LATENCY); i++) begin
      pipe_data[i] <= pipe_data[i-1];
      pipe_tag[i]  <= pipe_tag[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld <= (pipe_vld << 1) | LATENCY'(rd_fire);
    end
  end

  assign out_vld  = pipe_vld[LATENCY-1];
  assign out_data = pipe_data[LATENCY-1];
  assign out_tag  = pipe_tag[LATENCY-1];

  // FIFO bypass: a fresh response goes straight out when nothing older is queued.
  assign q_empty       = (count == '0);
  assign mem_rsp_valid = q_empty ? out_vld : 1'b1;
  assign mem_rsp_data  = q_empty ? out_data : q_data[rptr];
  assign mem_rsp_tag   = q_empty ? out_tag : q_tag[rptr];
  assign rsp_fire      = mem_rsp_valid && mem_rsp_ready;
  assign push          = out_vld && !(q_empty && mem_rsp_ready);
  assign pop           = !q_empty && mem_rsp_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wptr] <= out_data;
      q_tag[wptr]  <= out_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      pending <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + (QW + 1)'(push) - (QW + 1)'(pop);
      unique case ({rd_fire, rsp_fire})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

endmodule
